// File: rtl/network_injector.sv
// Network interface injector: turns a (dest, len) request plus payload words into
// head/body/tail flits for a mesh router's local input port, with a forced idle gap after each flit.
module network_injector #(
  parameter int LINK_WIDTH = 8,
  parameter int MESH_DIM   = 4,
  parameter int MAX_LEN    = 15,
  parameter int MIN_GAP    = 1,
  localparam int DEST_W    = $clog2(MESH_DIM*MESH_DIM),
  localparam int LEN_W     = $clog2(MAX_LEN+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DEST_W-1:0]     req_dest,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  pay_valid,
  output logic                  pay_ready,
  input  logic [LINK_WIDTH-3:0] pay_data,
  output logic [LINK_WIDTH-1:0] ni_out_flit,
  output logic                  ni_out_wr_en,
  input  logic                  ni_in_full,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PAYLOAD, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [LINK_WIDTH-1:0] flit_q, flit_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  wr_en, pay_rdy, wrote;
  logic [LEN_W-1:0]      len_clamped;

  always_comb begin
    if ({1'b0, req_len} > (LEN_W+1)'(MAX_LEN)) len_clamped = LEN_W'(MAX_LEN);
    else                                        len_clamped = req_len;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    flit_d  = flit_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    pay_rdy = 1'b0;
    wrote   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          rem_d   = len_clamped;
          flit_d  = {(len_clamped == '0) ? 2'b11 : 2'b01, (LINK_WIDTH-2)'(req_dest)};
          state_d = S_HEAD;
        end
      end
      S_HEAD: begin
        if (!ni_in_full) begin
          wr_en = 1'b1;
          wrote = 1'b1;
          if (rem_q == '0) cnt_d = cnt_q + 16'd1;
        end
      end
      S_PAYLOAD: begin
        if (!ni_in_full && pay_valid) begin
          wr_en   = 1'b1;
          pay_rdy = 1'b1;
          wrote   = 1'b1;
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = (rem_q != '0) ? S_PAYLOAD : S_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (wrote) begin
      if (MIN_GAP == 0) begin
        state_d = (rem_d != '0) ? S_PAYLOAD : S_IDLE;
      end else begin
        state_d = S_GAP;
        gap_d   = GAP_W'(MIN_GAP - 1);
      end
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      flit_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      flit_q  <= flit_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Body/tail words pass straight through so the payload word is consumed in its own write cycle.
  assign ni_out_flit  = (state_q == S_PAYLOAD) ?
                        {(rem_q == LEN_W'(1)) ? 2'b10 : 2'b00, pay_data} : flit_q;
  assign ni_out_wr_en = wr_en;
  assign pay_ready    = pay_rdy;
  assign req_ready    = ready_q;
  assign busy         = (state_q != S_IDLE);
  assign pkt_count    = cnt_q;

endmodule

// File: tb/tb_network_injector.sv
// Randomized bench for network_injector: expected flit streams are built per packet
// from the request and payload words and compared at every write strobe.
module tb_network_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_dest, req_len;
  logic        pay_valid, pay_ready;
  logic [5:0]  pay_data;
  logic [7:0]  ni_out_flit;
  logic        ni_out_wr_en, ni_in_full, busy;
  logic [15:0] pkt_count;

  network_injector #(.LINK_WIDTH(8), .MESH_DIM(4), .MAX_LEN(15), .MIN_GAP(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest), .req_len(req_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .ni_out_flit(ni_out_flit), .ni_out_wr_en(ni_out_wr_en), .ni_in_full(ni_in_full),
    .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          last_wr;
  logic [15:0] model_cnt = 16'd0;
  logic [7:0]  exp_q[$];
  logic [5:0]  pay_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid  = 1'b0;
    req_dest   = 4'h0;
    req_len    = 4'h0;
    pay_valid  = 1'b0;
    pay_data   = 6'h00;
    ni_in_full = 1'b0;
  endtask

  // Sends one packet (payload taken from pay_q) and checks every flit, the gap, and the counter.
  task automatic run_packet(input logic [3:0] dest, input int len,
                            input int full_pct, input int stall_pct, input bit strict);
    int  guard;
    int  pidx;
    bit  first;
    logic [7:0] ef;
    guard = 0;
    do begin
      tick();
      drive_idle();
      req_valid = 1'b1;
      req_dest  = dest;
      req_len   = 4'(len);
      #3;
      guard++;
    end while (!req_ready && guard < 10);
    chk("req_ready_accept", req_ready, 1);

    exp_q.delete();
    exp_q.push_back({(len == 0) ? 2'b11 : 2'b01, 2'b00, dest});
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len-1) ? 2'b10 : 2'b00, pay_q[i]});

    pidx  = 0;
    first = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      tick();
      guard++;
      req_valid  = busy ? 1'($urandom_range(1)) : 1'b0;
      req_dest   = 4'($urandom);
      req_len    = 4'($urandom);
      ni_in_full = ($urandom_range(99) < full_pct);
      pay_valid  = !($urandom_range(99) < stall_pct);
      pay_data   = (pidx < len) ? pay_q[pidx] : 6'($urandom);
      #3;
      if (ni_out_wr_en) begin
        chk("wr_while_full", ni_in_full, 0);
        if (!first) begin
          chk("gap_respected", (cyc - last_wr) > 1, 1);
          if (strict) chk("write_spacing", cyc - last_wr, 2);
        end
        ef = exp_q.pop_front();
        chk("flit", ni_out_flit, ef);
        chk("pay_ready_on_write", pay_ready, !ef[6]);
        if (pay_ready) pidx++;
        last_wr = cyc;
        first   = 1'b0;
      end else if (pay_ready) begin
        chk("pay_ready_without_write", pay_ready, 0);
      end
    end
    chk("packet_timeout", exp_q.size(), 0);
    model_cnt = model_cnt + 16'd1;

    tick();
    drive_idle();
    #3;
    chk("pkt_count", pkt_count, model_cnt);
    chk("busy_in_gap", busy, 1);
    tick();
    #3;
    chk("busy_after_gap", busy, 0);
    chk("req_ready_after_gap", req_ready, 1);
  endtask

  task automatic fill_random(input int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(6'($urandom));
  endtask

  initial begin
    int len;
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_wr_en", ni_out_wr_en, 0);
    chk("rst_flit", ni_out_flit, 0);
    chk("rst_pay_ready", pay_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("req_ready_before_first_edge", req_ready, 0);

    // single flit to router 5
    pay_q.delete();
    run_packet(4'h5, 0, 0, 0, 1'b0);

    // three payload words, no back-pressure: one write every second cycle
    pay_q = '{6'h01, 6'h02, 6'h03};
    run_packet(4'h5, 3, 0, 0, 1'b1);

    // heavy ni_in_full, then heavy pay_valid stalls
    fill_random(5);
    run_packet(4'hA, 5, 70, 0, 1'b0);
    fill_random(4);
    run_packet(4'h3, 4, 0, 60, 1'b0);

    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(15);
      fill_random(len);
      run_packet(4'($urandom), len, 25, 25, 1'b0);
    end

    // reset in the gap right after the head flit
    tick();
    drive_idle();
    req_valid = 1'b1;
    req_dest  = 4'h3;
    req_len   = 4'h3;
    #3;
    chk("abort_accept", req_ready, 1);
    tick();
    drive_idle();
    #3;
    chk("abort_head_wr", ni_out_wr_en, 1);
    chk("abort_head_flit", ni_out_flit, 8'h43);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", ni_out_wr_en, 0);
    chk("abort_flit", ni_out_flit, 0);
    chk("abort_pkt_count", pkt_count, 0);
    chk("abort_req_ready", req_ready, 0);
    model_cnt = 16'd0;
    tick();
    #2;
    rst = 1'b0;
    fill_random(2);
    run_packet(4'h9, 2, 0, 0, 1'b1);

    // counter wrap: preload near the top, then two packets
    #2;
    force dut.cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.cnt_q;
    model_cnt = 16'hFFFE;
    pay_q.delete();
    run_packet(4'h1, 0, 0, 0, 1'b0);
    run_packet(4'h2, 0, 0, 0, 1'b0);
    chk("pkt_count_wrapped", pkt_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/network_injector.md
NETWORK_INJECTOR -- requirements
Module: network_injector

Interface
REQ-001 Parameter LINK_WIDTH, default 8, width of the flit link in bits.
REQ-002 Parameter MESH_DIM, default 4; DEST_W = $clog2(MESH_DIM*MESH_DIM) bits of destination router ID.
REQ-003 Parameter MAX_LEN, default 15; LEN_W = $clog2(MAX_LEN+1) bits of payload-flit count.
REQ-004 Parameter MIN_GAP, default 1, number of idle cycles forced after every flit write.
REQ-005 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  packet request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_dest  input  DEST_W  destination router ID.
REQ-010 req_len  input  LEN_W  number of payload flits, 0..MAX_LEN.
REQ-011 pay_valid  input  1  payload word present.
REQ-012 pay_ready  output  1  payload word consumed this cycle.
REQ-013 pay_data  input  LINK_WIDTH-2  payload word.
REQ-014 ni_out_flit  output  LINK_WIDTH  flit to the router's local input buffer.
REQ-015 ni_out_wr_en  output  1  write strobe to the router's local input buffer.
REQ-016 ni_in_full  input  1  registered (one-cycle-delayed) full flag of the router's local input buffer.
REQ-017 busy  output  1  a packet is in progress.
REQ-018 pkt_count  output  16  packets completed, wraps at 16'hFFFF -> 0.

Function
REQ-019 Flit bits [LINK_WIDTH-1:LINK_WIDTH-2] SHALL encode type: 01 head, 00 body, 10 tail, 11 single (head+tail).
REQ-020 Head/single flit SHALL carry req_dest in [DEST_W-1:0]; all remaining bits zero.
REQ-021 Body/tail flit SHALL carry pay_data in [LINK_WIDTH-3:0].
REQ-022 FSM states SHALL be IDLE, HEAD, PAYLOAD, GAP.
REQ-023 req_ready SHALL equal 1 only in IDLE.
REQ-024 IDLE: on req_valid&&req_ready, latch req_dest and req_len, go to HEAD next cycle.
REQ-025 HEAD: when ni_in_full==0, assert ni_out_wr_en for one cycle with head flit (single flit if latched len==0), then go to GAP.
REQ-026 PAYLOAD: when ni_in_full==0 and pay_valid==1, assert ni_out_wr_en and pay_ready in the same cycle, emit body flit, or tail flit if it is the last latched payload word; decrement remaining count; go to GAP.
REQ-027 PAYLOAD with ni_in_full==1 or pay_valid==0: no write, pay_ready=0, stay.
REQ-028 GAP: hold ni_out_wr_en=0 for exactly MIN_GAP cycles, then go to PAYLOAD if payload flits remain, else IDLE.
REQ-029 MIN_GAP==0: GAP SHALL be skipped (transition directly).
REQ-030 ni_out_wr_en SHALL never assert in a cycle where ni_in_full==1.
REQ-031 ni_out_flit SHALL be registered; value outside write cycles is don't-care but SHALL be stable within the write cycle.
REQ-032 pkt_count SHALL increment by 1 in the cycle the tail or single flit is written.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 req_len beyond MAX_LEN (only possible when MAX_LEN+1 is not a power of two) SHALL be clamped to MAX_LEN.
REQ-035 req_valid, req_dest, req_len SHALL be ignored outside IDLE; no request queueing.
REQ-036 Back-to-back packets: after a tail GAP, IDLE then accepts a new request the same cycle it is entered.

Reset
REQ-037 While rst==1: state=IDLE, ni_out_wr_en=0, ni_out_flit=0, pay_ready=0, busy=0, pkt_count=0, req_ready=0.
REQ-038 Reset asserted mid-packet SHALL abort the packet immediately; no tail is emitted and pkt_count is not incremented.
REQ-039 First request SHALL be accepted no earlier than the first rising edge after rst deasserts.

Verification
REQ-040 Single flit: req_dest=4'h5, req_len=0, ni_in_full=0 -> one write, flit 8'hC5, pkt_count=1, busy low after one GAP cycle.
REQ-041 Three-payload packet, MIN_GAP=1, payload 6'h01,6'h02,6'h03 -> writes 8'h4x head, 8'h01, 8'h02, 8'h83 on every second cycle.
REQ-042 ni_in_full held high 5 cycles during PAYLOAD -> no writes, no pay_ready during those cycles; resumes with same payload word when full drops.
REQ-043 pay_valid low mid-packet -> FSM stalls in PAYLOAD, no write; tail still correct afterwards.
REQ-044 rst pulsed after head written -> outputs return to reset values asynchronously; next request starts a fresh head.
REQ-045 pkt_count at 16'hFFFF plus one packet -> 16'h0000.
